// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: posted-store FIFO in front of data memory, with stores and loads serialised by an IDLE/REQ/BUSY FSM
module dmem_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [3:0]  sign_mask,
    output logic [31:0] read_data,
    output logic        stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;
    state_t        state;
    logic [AW:0]   count;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [31:0]   q_addr [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [3:0]    q_mask [DEPTH];
    logic          ld_done, busy_first, cur_load;
    logic          full, empty, push, pop, issue_ld;
    assign full     = count == (AW+1)'(DEPTH);
    assign empty    = count == '0;
    assign push     = memwrite & ~full;
    assign pop      = (state == IDLE) & ~empty;
    // queued stores always drain before a load, so loads never need forwarding
    assign issue_ld = (state == IDLE) & empty & memread & ~memwrite & ~ld_done;
    assign stall    = (memread & ~memwrite & ~ld_done) | (memwrite & full);
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= addr;
            q_data[wr_ptr] <= write_data;
            q_mask[wr_ptr] <= sign_mask;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            count          <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            ld_done        <= 1'b0;
            busy_first     <= 1'b0;
            cur_load       <= 1'b0;
            read_data      <= '0;
            mem_memwrite   <= 1'b0;
            mem_memread    <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            mem_sign_mask  <= '0;
        end else begin
            mem_memwrite <= pop;
            mem_memread  <= issue_ld;
            ld_done      <= 1'b0;
            count        <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            case (state)
                IDLE: begin
                    if (pop) begin
                        mem_addr       <= q_addr[rd_ptr];
                        mem_write_data <= q_data[rd_ptr];
                        mem_sign_mask  <= q_mask[rd_ptr];
                        rd_ptr         <= rd_ptr + AW'(1);
                        cur_load       <= 1'b0;
                        state          <= REQ;
                    end else if (issue_ld) begin
                        mem_addr       <= addr;
                        mem_write_data <= write_data;
                        mem_sign_mask  <= sign_mask;
                        cur_load       <= 1'b1;
                        state          <= REQ;
                    end
                end
                REQ: begin
                    busy_first <= 1'b1;
                    state      <= BUSY;
                end
                BUSY: begin
                    busy_first <= 1'b0;
                    // the busy flag only appears a cycle after the strobe, so ignore it on the first BUSY cycle
                    if (!busy_first && !mem_clk_stall) begin
                        state <= IDLE;
                        if (cur_load) begin
                            read_data <= mem_read_data;
                            ld_done   <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: directed checks of dmem_store_buffer against a behavioural data memory
module tb_dmem_store_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr, write_data, read_data, mem_addr, mem_write_data, mem_read_data;
    logic        memwrite, memread, stall, mem_memwrite, mem_memread, mem_clk_stall;
    logic [3:0]  sign_mask, mem_sign_mask;
    logic [31:0] mem [16];
    logic [31:0] wlog [$];
    int          bc = 0;
    int          busy_len = 1;
    int          rd_strobes = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          rd0, wb;
    dmem_store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .addr(addr), .write_data(write_data),
        .memwrite(memwrite), .memread(memread), .sign_mask(sign_mask),
        .read_data(read_data), .stall(stall), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_memwrite(mem_memwrite),
        .mem_memread(mem_memread), .mem_sign_mask(mem_sign_mask),
        .mem_read_data(mem_read_data), .mem_clk_stall(mem_clk_stall)
    );
    always #5 clk = ~clk;
    // busy rises the cycle after a strobe and lasts busy_len cycles
    assign mem_clk_stall = bc != 0;
    assign mem_read_data = (mem_addr == 32'h2000) ? 32'h12345678 : mem[mem_addr[5:2]];
    always @(posedge clk) begin
        if (!rst_n) bc <= 0;
        else begin
            if (mem_memwrite || mem_memread) bc <= busy_len;
            else if (bc != 0) bc <= bc - 1;
            if (mem_memwrite) begin
                mem[mem_addr[5:2]] <= mem_write_data;
                wlog.push_back(mem_write_data);
            end
            if (mem_memread) rd_strobes <= rd_strobes + 1;
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic drive_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        memwrite = 1'b1;
        memread = 1'b0;
        addr = a;
        write_data = d;
        sign_mask = m;
        #1;
    endtask
    initial begin
        logic [31:0] exp_b2b [6];
        exp_b2b = '{32'hB0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
        rst_n = 1'b0; memwrite = 1'b0; memread = 1'b0;
        addr = '0; write_data = '0; sign_mask = '0;
        tick(); tick();
        chk("rst_memwrite", 32'(mem_memwrite), 0);
        chk("rst_memread", 32'(mem_memread), 0);
        chk("rst_read_data", read_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_count", 32'(dut.count), 0);
        rst_n = 1'b1;
        tick(); tick();
        // single store
        drive_st(32'h1004, 32'hDEADBEEF, 4'b0100);
        chk("st_stall", 32'(stall), 0);
        tick(); memwrite = 1'b0;
        chk("st_count1", 32'(dut.count), 1);
        chk("st_nostrobe", 32'(mem_memwrite), 0);
        tick();
        chk("st_strobe", 32'(mem_memwrite), 1);
        chk("st_addr", mem_addr, 32'h1004);
        chk("st_data", mem_write_data, 32'hDEADBEEF);
        chk("st_mask", 32'(mem_sign_mask), 32'h4);
        chk("st_count0", 32'(dut.count), 0);
        tick();
        chk("st_strobe_end", 32'(mem_memwrite), 0);
        chk("st_addr_hold", mem_addr, 32'h1004);
        tick(); tick();
        chk("st_idle", 32'(dut.state), 0);
        chk("st_mem", mem[1], 32'hDEADBEEF);
        // back-to-back stores behind a slow store
        busy_len = 6;
        wb = wlog.size();
        drive_st(32'h1024, 32'hB0, 4'hF);
        tick(); memwrite = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            drive_st(32'h1010 + 32'(4 * i), 32'hA0 + 32'(i), 4'h0);
            chk($sformatf("b2b_stall%0d", i), 32'(stall), (i == 4) ? 32'd1 : 32'd0);
            if (i < 4) tick();
        end
        chk("b2b_full", 32'(dut.count), 4);
        tick(); tick(); tick(); tick();
        chk("b2b_pop_cycle_stall", 32'(stall), 1);
        tick();
        busy_len = 1;
        chk("b2b_admit_stall", 32'(stall), 0);
        chk("b2b_admit_count", 32'(dut.count), 3);
        tick(); memwrite = 1'b0;
        chk("b2b_refill", 32'(dut.count), 4);
        for (int i = 0; i < 150 && wlog.size() < wb + 6; i++) tick();
        chk("b2b_drained", wlog.size(), wb + 6);
        for (int i = 0; i < 6; i++) chk($sformatf("b2b_order%0d", i), (wb + i < wlog.size()) ? wlog[wb + i] : 32'hX, exp_b2b[i]);
        tick(); tick(); tick();
        // load behind two stores
        wb = wlog.size();
        rd0 = rd_strobes;
        drive_st(32'h1004, 32'h11111111, 4'h0);
        tick();
        drive_st(32'h1004, 32'h22222222, 4'h0);
        tick();
        memwrite = 1'b0; memread = 1'b1; addr = 32'h1004; #1;
        chk("lbs_stall", 32'(stall), 1);
        for (int i = 0; i < 60 && stall; i++) begin
            if (mem_memread) begin
                chk("lbs_after_stores", wlog.size(), wb + 2);
                chk("lbs_fifo_empty", 32'(dut.count), 0);
            end
            tick();
        end
        chk("lbs_stall_fell", 32'(stall), 0);
        chk("lbs_ld_done", 32'(dut.ld_done), 1);
        chk("lbs_data", read_data, 32'h22222222);
        memread = 1'b0;
        tick(); tick();
        chk("lbs_one_load", rd_strobes - rd0, 1);
        // load on empty FIFO
        rd0 = rd_strobes;
        memread = 1'b1; addr = 32'h2000; #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("ld_stall%0d", k), 32'(stall), 1);
            tick();
        end
        chk("ld_stall_low", 32'(stall), 0);
        chk("ld_data", read_data, 32'h12345678);
        memread = 1'b0;
        tick(); tick(); tick();
        chk("ld_one_load", rd_strobes - rd0, 1);
        // reset during BUSY with three stores queued
        busy_len = 6;
        for (int i = 0; i < 4; i++) begin
            drive_st(32'h1030 + 32'(4 * i), 32'hC0 + 32'(i), 4'h1);
            tick();
        end
        memwrite = 1'b0; #1;
        chk("mid_count", 32'(dut.count), 3);
        chk("mid_busy", 32'(dut.state), 2);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_count", 32'(dut.count), 0);
        chk("mid_rst_state", 32'(dut.state), 0);
        chk("mid_rst_addr", mem_addr, 0);
        chk("mid_rst_wdata", mem_write_data, 0);
        chk("mid_rst_mask", 32'(mem_sign_mask), 0);
        chk("mid_rst_rdata", read_data, 0);
        chk("mid_rst_stall", 32'(stall), 0);
        wb = wlog.size();
        tick();
        rst_n = 1'b1; busy_len = 1;
        for (int i = 0; i < 20; i++) tick();
        chk("mid_no_more_writes", wlog.size(), wb);
        // first store issued right after release
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        drive_st(32'h1034, 32'h55, 4'h2);
        tick(); memwrite = 1'b0;
        chk("rel_count", 32'(dut.count), 1);
        tick();
        chk("rel_strobe", 32'(mem_memwrite), 1);
        tick(); tick(); tick();
        // simultaneous store and load
        rd0 = rd_strobes;
        wb = wlog.size();
        memwrite = 1'b1; memread = 1'b1; addr = 32'h1050; write_data = 32'h77; sign_mask = 4'h2; #1;
        chk("sim_stall", 32'(stall), 0);
        tick(); memwrite = 1'b0; memread = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("sim_no_load", rd_strobes - rd0, 0);
        chk("sim_one_store", wlog.size(), wb + 1);
        chk("sim_store_data", (wlog.size() > 0) ? wlog[wlog.size() - 1] : 32'hX, 32'h77);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
